// File: rtl/zbritesi_pkg.sv
// Shared constants and types for the bit-serial subtractor.
package zbritesi_pkg;

   // Default operand width
   localparam int W24 = 24;

   // Counter width for the default build
   localparam int CNT_W24 = $clog2(W24);

   // Controller state encoding
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   // Counter width needed to index every bit of an operand of width w
   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/zbritesi_bit.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow to next bit.
module zbritesi_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/zbritesi24_serial.sv
// Bit-serial WIDTH-bit subtractor, LSB first, START/READY/DONE handshake.
// Produces A - B - BIN with borrow, zero and signed-overflow flags.
module zbritesi24_serial
   import zbritesi_pkg::*;
#(
   parameter int WIDTH = W24
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             BIN,
   output logic             READY,
   output logic             DONE,
   output logic [WIDTH-1:0] Diferenca,
   output logic             BOUT,
   output logic             ZERO,
   output logic             OVERFLOW
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_r;
   state_t           next_state_s;
   logic [CW-1:0]    count_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] res_r;
   logic             br_r;
   logic             sign_a_r;
   logic             sign_b_r;

   logic [WIDTH-1:0] diff_r;
   logic             bout_r;
   logic             zero_r;
   logic             ovf_r;

   logic             accept_s;
   logic             last_s;
   logic             bit_d_s;
   logic             bit_bout_s;
   logic [WIDTH-1:0] res_next_s;

   // Single subtractor cell shared by every bit position
   zbritesi_bit u_bit (
      .a    (a_sh_r[0]),
      .b    (b_sh_r[0]),
      .bin  (br_r),
      .d    (bit_d_s),
      .bout (bit_bout_s)
   );

   // Next-state logic and handshake decode
   always_comb begin
      next_state_s = S_IDLE;
      accept_s     = 1'b0;
      last_s       = (count_r == LAST);
      res_next_s   = {bit_d_s, res_r[WIDTH-1:1]};
      case (state_r)
         S_IDLE: begin
            if (START) begin
               next_state_s = S_RUN;
               accept_s     = 1'b1;
            end else begin
               next_state_s = S_IDLE;
            end
         end
         S_RUN: begin
            if (last_s) begin
               next_state_s = S_FIN;
            end else begin
               next_state_s = S_RUN;
            end
         end
         S_FIN: begin
            // Back-to-back accept straight out of FIN
            if (START) begin
               next_state_s = S_RUN;
               accept_s     = 1'b1;
            end else begin
               next_state_s = S_IDLE;
            end
         end
         default: begin
            next_state_s = S_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Operand shift registers, borrow flop and bit counter
   always_ff @(posedge CLK) begin
      if (RST) begin
         a_sh_r   <= '0;
         b_sh_r   <= '0;
         res_r    <= '0;
         br_r     <= 1'b0;
         count_r  <= '0;
         sign_a_r <= 1'b0;
         sign_b_r <= 1'b0;
      end else if (accept_s) begin
         a_sh_r   <= A;
         b_sh_r   <= B;
         br_r     <= BIN;
         count_r  <= '0;
         sign_a_r <= A[WIDTH-1];
         sign_b_r <= B[WIDTH-1];
      end else if (state_r == S_RUN) begin
         a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
         b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
         br_r    <= bit_bout_s;
         res_r   <= res_next_s;
         count_r <= count_r + CW'(1);
      end else begin
         a_sh_r  <= a_sh_r;
         b_sh_r  <= b_sh_r;
      end
   end

   // Result and flags load only on the final RUN bit, then hold
   always_ff @(posedge CLK) begin
      if (RST) begin
         diff_r <= '0;
         bout_r <= 1'b0;
         zero_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if ((state_r == S_RUN) && last_s) begin
         diff_r <= res_next_s;
         bout_r <= bit_bout_s;
         zero_r <= (res_next_s == '0);
         ovf_r  <= (sign_a_r != sign_b_r) && (res_next_s[WIDTH-1] != sign_a_r);
      end else begin
         diff_r <= diff_r;
      end
   end

   // Handshake outputs decode directly from the state flops
   assign READY     = (state_r != S_RUN);
   assign DONE      = (state_r == S_FIN);
   assign Diferenca = diff_r;
   assign BOUT      = bout_r;
   assign ZERO      = zero_r;
   assign OVERFLOW  = ovf_r;

endmodule
